// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: result = A + (sub ? ~B : B) + (cin ^ sub).
// Latency STAGES cycles, one beat per cycle; a single global enable stalls every stage when the output is held.
module pipelined_cla_addsub #(
  parameter int N      = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int NG  = N / GROUP;
  localparam int GPS = NG / STAGES;

  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] a_d   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] b_d   [STAGES];
  logic [N-1:0] sum_q [STAGES];
  logic [N-1:0] sum_d [STAGES];
  logic         c_q   [STAGES];
  logic         c_d   [STAGES];
  logic         sa_q  [STAGES];
  logic         sa_d  [STAGES];
  logic         sb_q  [STAGES];
  logic         sb_d  [STAGES];
  logic         v_q   [STAGES];
  logic         v_d   [STAGES];

  logic [N-1:0] src_a   [STAGES];
  logic [N-1:0] src_b   [STAGES];
  logic [N-1:0] src_sum [STAGES];
  logic         src_c   [STAGES];
  logic         src_sa  [STAGES];
  logic         src_sb  [STAGES];
  logic         src_v   [STAGES];

  logic             adv;
  logic [GROUP-1:0] bg;
  logic [GROUP-1:0] bp;
  logic [GROUP:0]   cv;
  logic [GPS-1:0]   gg;
  logic [GPS-1:0]   gp;
  logic [GPS:0]     sc;
  logic [N-1:0]     sum_n;

  // Sum-of-products carries: c[j] = cin&p[j-1:0] | OR_k g[k]&p[j-1:k+1]; no ripple term.
  function automatic logic [GROUP:0] grp_carries(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic cin);
    logic [GROUP:0] c;
    logic           term;
    for (int j = 0; j <= GROUP; j++) begin
      c[j] = cin;
      for (int m = 0; m < j; m++) c[j] = c[j] & p[m];
      for (int k = 0; k < j; k++) begin
        term = g[k];
        for (int m = k + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

  function automatic logic [GPS:0] stg_carries(input logic [GPS-1:0] g,
                                               input logic [GPS-1:0] p,
                                               input logic cin);
    logic [GPS:0] c;
    logic         term;
    for (int j = 0; j <= GPS; j++) begin
      c[j] = cin;
      for (int m = 0; m < j; m++) c[j] = c[j] & p[m];
      for (int k = 0; k < j; k++) begin
        term = g[k];
        for (int m = k + 1; m < j; m++) term = term & p[m];
        c[j] = c[j] | term;
      end
    end
    return c;
  endfunction

  always_comb begin
    adv   = !v_q[STAGES-1] || out_ready;
    bg    = '0;
    bp    = '0;
    cv    = '0;
    gg    = '0;
    gp    = '0;
    sc    = '0;
    sum_n = '0;

    src_a[0]   = in_a;
    src_b[0]   = in_sub ? ~in_b : in_b;
    src_c[0]   = in_cin ^ in_sub;
    src_sum[0] = '0;
    src_sa[0]  = in_a[N-1];
    src_sb[0]  = in_sub ? ~in_b[N-1] : in_b[N-1];
    src_v[0]   = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_c[s]   = c_q[s-1];
      src_sum[s] = sum_q[s-1];
      src_sa[s]  = sa_q[s-1];
      src_sb[s]  = sb_q[s-1];
      src_v[s]   = v_q[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
      sum_d[s] = sum_q[s];
      c_d[s]   = c_q[s];
      sa_d[s]  = sa_q[s];
      sb_d[s]  = sb_q[s];
      v_d[s]   = src_v[s];

      for (int k = 0; k < GPS; k++) begin
        bg    = src_a[s][(s*GPS+k)*GROUP +: GROUP] & src_b[s][(s*GPS+k)*GROUP +: GROUP];
        bp    = src_a[s][(s*GPS+k)*GROUP +: GROUP] ^ src_b[s][(s*GPS+k)*GROUP +: GROUP];
        cv    = grp_carries(bg, bp, 1'b0);
        gg[k] = cv[GROUP];
        gp[k] = &bp;
      end
      sc    = stg_carries(gg, gp, src_c[s]);
      sum_n = src_sum[s];
      for (int k = 0; k < GPS; k++) begin
        bg = src_a[s][(s*GPS+k)*GROUP +: GROUP] & src_b[s][(s*GPS+k)*GROUP +: GROUP];
        bp = src_a[s][(s*GPS+k)*GROUP +: GROUP] ^ src_b[s][(s*GPS+k)*GROUP +: GROUP];
        cv = grp_carries(bg, bp, sc[k]);
        sum_n[(s*GPS+k)*GROUP +: GROUP] = bp ^ cv[GROUP-1:0];
      end

      // Data registers only load on a real beat; bubbles leave them untouched.
      if (src_v[s]) begin
        a_d[s]   = src_a[s];
        b_d[s]   = src_b[s];
        sum_d[s] = sum_n;
        c_d[s]   = sc[GPS];
        sa_d[s]  = src_sa[s];
        sb_d[s]  = src_sb[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]   <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
        sa_q[s]  <= 1'b0;
        sb_q[s]  <= 1'b0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]   <= v_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
        c_q[s]   <= c_d[s];
        sa_q[s]  <= sa_d[s];
        sb_q[s]  <= sb_d[s];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = (sa_q[STAGES-1] == sb_q[STAGES-1]) && (sum_q[STAGES-1][N-1] != sa_q[STAGES-1]);

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: four instances (STAGES = 1, 2, 4, 8) share one stimulus stream;
// each has its own in-order scoreboard fed by an arithmetic reference model.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic        cout;
    logic        ovf;
    logic [31:0] sum;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_cin;
  logic        out_ready;

  logic [3:0]  in_ready_w;
  logic [3:0]  out_valid_w;
  logic [3:0]  out_cout_w;
  logic [3:0]  out_ovf_w;
  logic [31:0] out_sum_w [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    longint ua, ub, sa, sb, ci, ur, sr;
    exp_t   r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ci = {63'd0, cin};
    if (sub) begin
      ur     = ua - ub - ci;
      sr     = sa - sb - ci;
      r.cout = (ur >= 0);
    end else begin
      ur     = ua + ub + ci;
      sr     = sa + sb + ci;
      r.cout = (ur >= 64'sh1_0000_0000);
    end
    r.sum = ur[31:0];
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    pipelined_cla_addsub #(.N(32), .GROUP(4), .STAGES(1 << gi)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready_w[gi]),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_sub   (in_sub),
      .in_cin   (in_cin),
      .out_valid(out_valid_w[gi]),
      .out_ready(out_ready),
      .out_sum  (out_sum_w[gi]),
      .out_cout (out_cout_w[gi]),
      .out_ovf  (out_ovf_w[gi])
    );

    exp_t        q[$];
    exp_t        e;
    logic        stall_q = 1'b0;
    logic [33:0] held = '0;
    int          q_len = 0;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q)
          check($sformatf("hold_s%0d", 1 << gi),
                {out_valid_w[gi], out_cout_w[gi], out_ovf_w[gi], out_sum_w[gi]}, {1'b1, held});
        if (out_valid_w[gi] && !out_ready)
          check($sformatf("in_ready_stall_s%0d", 1 << gi), in_ready_w[gi], 0);
        if (out_valid_w[gi] && out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("spurious_s%0d", 1 << gi), out_valid_w[gi], 0);
          end else begin
            e = q.pop_front();
            check($sformatf("sb_s%0d", 1 << gi),
                  {out_cout_w[gi], out_ovf_w[gi], out_sum_w[gi]}, e);
          end
        end
        if (in_valid && in_ready_w[gi]) q.push_back(model(in_a, in_b, in_sub, in_cin));
        stall_q = out_valid_w[gi] && !out_ready;
        held    = {out_cout_w[gi], out_ovf_w[gi], out_sum_w[gi]};
      end
      q_len = q.size();
    end
  end

  task automatic check_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid_s%0d", tag, 1 << i), out_valid_w[i], 0);
      check($sformatf("%s_outs_s%0d", tag, 1 << i),
            {out_cout_w[i], out_ovf_w[i], out_sum_w[i]}, 0);
      check($sformatf("%s_in_ready_s%0d", tag, 1 << i), in_ready_w[i], 1);
    end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_left_s1"}, g_dut[0].q_len, 0);
    check({tag, "_left_s2"}, g_dut[1].q_len, 0);
    check({tag, "_left_s4"}, g_dut[2].q_len, 0);
    check({tag, "_left_s8"}, g_dut[3].q_len, 0);
  endtask

  task automatic rand_beat();
    in_a   = $urandom();
    in_b   = $urandom();
    in_sub = 1'($urandom_range(0, 1));
    in_cin = 1'($urandom_range(0, 1));
  endtask

  initial begin
    vec_t tbl[8];
    int   lat[4];
    exp_t got[4];
    exp_t want;
    int   run, maxrun, sent, cyc, stalls;
    logic hs;

    tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[2] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("reset");

    // Directed vectors, one at a time: value and per-instance latency.
    for (int v = 0; v < 8; v++) begin
      in_a = tbl[v].a; in_b = tbl[v].b; in_sub = tbl[v].sub; in_cin = tbl[v].cin;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin lat[i] = 0; got[i] = '0; end
      for (int c = 1; c <= 10; c++) begin
        for (int i = 0; i < 4; i++)
          if (out_valid_w[i] && lat[i] == 0) begin
            lat[i] = c;
            got[i] = {out_cout_w[i], out_ovf_w[i], out_sum_w[i]};
          end
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_latency_s%0d", v, 1 << i), lat[i], 1 << i);
        check($sformatf("vec%0d_result_s%0d", v, 1 << i), got[i],
              {tbl[v].cout, tbl[v].ovf, tbl[v].sum});
      end
    end

    // Back-to-back random stream at full rate.
    run = 0; maxrun = 0;
    for (int b = 0; b < 26; b++) begin
      if (b < 16) begin rand_beat(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      run    = out_valid_w[1] ? run + 1 : 0;
      maxrun = (run > maxrun) ? run : maxrun;
    end
    check("stream_consecutive_valid", maxrun, 16);
    check_drained("stream");

    // Backpressure: out_ready low for 5 cycles mid-stream, driver honours in_ready.
    sent = 0; cyc = 0; stalls = 0;
    rand_beat(); in_valid = 1'b1;
    while (sent < 20 && cyc < 200) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      hs = in_ready_w[1];
      @(posedge clk); #1;
      cyc++;
      if (hs) begin sent++; rand_beat(); end
      else stalls++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_beats_sent", sent, 20);
    check("bp_stall_cycles", stalls, 5);
    repeat (12) begin @(posedge clk); #1; end
    check_drained("bp");

    // Reset with two beats in flight.
    in_a = 32'h11111111; in_b = 32'h22222222; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h33333333; in_b = 32'h44444444;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("midreset");
    in_a = 32'h0F0F0F0F; in_b = 32'h01010101; in_sub = 1'b0; in_cin = 1'b1; in_valid = 1'b1;
    want = model(in_a, in_b, in_sub, in_cin);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat[1] = 0; got[1] = '0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid_w[1] && lat[1] == 0) begin
        lat[1] = c;
        got[1] = {out_cout_w[1], out_ovf_w[1], out_sum_w[1]};
      end
      @(posedge clk); #1;
    end
    check("post_reset_latency", lat[1], 2);
    check("post_reset_first_result", got[1], want);
    check_drained("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
